mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255; the maximum number of WAIT cycles before an access is aborted, range 1..255.
REQ-002 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 Port reset_n  in  1  asynchronous, active-low reset.
REQ-004 Port MemRead_in  in  1  load request from the EX/MEM register.
REQ-005 Port MemWrite_in  in  1  store request from the EX/MEM register.
REQ-006 Port WBdata_in  in  1  write-back select: 1 = memory data, 0 = ALU result.
REQ-007 Port RegWrite_in  in  1  register write enable from the EX/MEM register.
REQ-008 Port ALU_result_in  in  32  effective address, or the value to write back.
REQ-009 Port BusB_in  in  32  store data.
REQ-010 Port dest_reg_in  in  4  destination register.
REQ-011 Port PC_in  in  32  instruction PC.
REQ-012 Port mem_req, mem_we  out  1 each  data-memory request and write strobe.
REQ-013 Port mem_addr, mem_wdata  out  32 each  data-memory address and write data.
REQ-014 Port mem_ack  in  1  data-memory completion; valid only while mem_req=1.
REQ-015 Port mem_rdata  in  32  load data, valid in the mem_ack cycle.
REQ-016 Port stall_out  out  1  combinational; holds IF/ID/EX/EX_MEM when asserted.
REQ-017 Port RegWrite_out, dest_reg_out[3:0], WB_value_out[31:0], PC_out[31:0]  out  the MEM/WB register outputs.
REQ-018 Port mem_err  out  1  sticky error flag; set on timeout or on a misaligned access.

Function
REQ-019 Define access = MemRead_in | MemWrite_in; when both are 1, the block SHALL perform a write.
REQ-020 The FSM SHALL have two states, IDLE and WAIT.
REQ-021 IDLE, access=0: the MEM/WB outputs SHALL load the inputs at the next edge (latency 1).
  - WB_value_out = ALU_result_in.
  - RegWrite_out = RegWrite_in.
REQ-022 IDLE, access=1, ALU_result_in[1:0]=00: the block SHALL assert stall_out.
  - Capture address, wdata, we, WBdata, RegWrite, dest_reg and PC into internal registers.
  - Go to WAIT.
  - At that edge, load a bubble into MEM/WB: RegWrite_out=0, PC_out=32'hFFFFFFFF.
REQ-023 IDLE, access=1, misaligned address: the block SHALL issue no memory request and SHALL NOT stall.
  - MEM/WB gets the instruction with RegWrite_out forced to 0.
  - mem_err is set.
REQ-024 WAIT: mem_req SHALL be 1; mem_addr, mem_wdata and mem_we SHALL come from the captured registers and stay stable until ack.
REQ-025 WAIT: stall_out SHALL equal ~mem_ack; mem_req=0 in IDLE; inputs are ignored in WAIT.
REQ-026 WAIT, mem_ack=1: the block SHALL return to IDLE and load MEM/WB from the captured registers.
  - WB_value_out = mem_rdata if the captured WBdata=1, else the captured address.
  - RegWrite_out = captured RegWrite.
REQ-027 The access-to-writeback latency SHALL be N+1 edges, where N is the number of WAIT cycles (≥1), ack included.
REQ-028 A 9-bit wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without ack.
  - When it reaches TIMEOUT with no ack: drop mem_req, go to IDLE, load a bubble into MEM/WB, set mem_err, deassert stall.
  - The aborted instruction is lost.
REQ-029 An ack arriving in the same cycle the count reaches TIMEOUT SHALL win; the access completes normally.
REQ-030 mem_ack while in IDLE SHALL be ignored.
REQ-031 Back-to-back accesses SHALL be supported: after ack, the next access is issued from IDLE on the following cycle.

Reset
REQ-032 When reset_n=0, asynchronously and regardless of state, the block SHALL force:
  - state=IDLE, counter=0;
  - mem_req=mem_we=0, mem_addr=mem_wdata=0;
  - RegWrite_out=0, dest_reg_out=0, WB_value_out=0;
  - PC_out=32'hFFFFFFFF;
  - mem_err=0.
REQ-033 A reset during WAIT SHALL abandon the access; mem_req falls without waiting for ack.
REQ-034 mem_err SHALL clear only on reset.

Verification
REQ-035 ALU-only: RegWrite_in=1, dest=4'h3, ALU=32'h1234, access=0 -> next edge RegWrite_out=1, dest_reg_out=3, WB_value_out=32'h1234, stall_out=0 throughout.
REQ-036 Load, ack after 3 WAIT cycles: addr=32'h100, mem_rdata=32'hCAFEBABE -> mem_req=1 for 3 cycles, stall_out=1 until the ack cycle, WB_value_out=32'hCAFEBABE, RegWrite_out=1 after 4 edges.
REQ-037 Store: MemWrite=1, addr=32'h200, BusB=32'hDEADBEEF, ack in the first WAIT cycle -> mem_we=1, mem_wdata=32'hDEADBEEF; MEM/WB gets RegWrite_out=0 when RegWrite_in=0.
REQ-038 Timeout: TIMEOUT=4, load, never ack -> mem_req drops after 4 WAIT cycles, mem_err=1, bubble in MEM/WB, stall_out=0.
REQ-039 Misaligned: MemRead=1, addr=32'h102 -> no mem_req, no stall, RegWrite_out=0, mem_err=1.
REQ-040 Reset in WAIT: reset_n=0 during the second WAIT cycle -> mem_req=0 immediately, PC_out=32'hFFFFFFFF, mem_err=0, state IDLE after release.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Purpose: MEM pipeline stage controller with a data-memory handshake and the MEM/WB register.
// Latency: 1 edge for non-memory instructions; N+1 edges for an access that takes N WAIT cycles.
// Backpressure: stall_out holds the upstream stages while an access is pending (drops in the ack cycle).
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        WBdata_in,
  input  logic        RegWrite_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] BusB_in,
  input  logic [3:0]  dest_reg_in,
  input  logic [31:0] PC_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_out,
  output logic        RegWrite_out,
  output logic [3:0]  dest_reg_out,
  output logic [31:0] WB_value_out,
  output logic [31:0] PC_out,
  output logic        mem_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [8:0]  LP_TIMEOUT = 9'(TIMEOUT);
  localparam logic [31:0] LP_BUBBLE_PC = 32'hFFFF_FFFF;

  state_t      r_state;
  logic [8:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_wbdata;
  logic        r_regwrite;
  logic [3:0]  r_dest;
  logic [31:0] r_pc;

  logic        r_wb_regwrite;
  logic [3:0]  r_wb_dest;
  logic [31:0] r_wb_value;
  logic [31:0] r_wb_pc;
  logic        r_err;

  logic        w_access;
  logic        w_aligned;
  logic        w_in_wait;
  logic        w_timeout;

  assign w_access  = MemRead_in | MemWrite_in;
  assign w_aligned = (ALU_result_in[1:0] == 2'b00);
  assign w_in_wait = (r_state == S_WAIT);
  // The abort fires in the cycle whose missing ack would bring the count to TIMEOUT.
  assign w_timeout = w_in_wait && !mem_ack && ((r_cnt + 9'd1) == LP_TIMEOUT);

  // Memory side is driven straight from the captured request; the strobes only exist in WAIT.
  assign mem_req   = w_in_wait;
  assign mem_we    = w_in_wait & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  // Hold upstream while an aligned access is being launched or is still waiting for its ack.
  assign stall_out = w_in_wait ? ~mem_ack : (w_access & w_aligned);

  assign RegWrite_out = r_wb_regwrite;
  assign dest_reg_out = r_wb_dest;
  assign WB_value_out = r_wb_value;
  assign PC_out       = r_wb_pc;
  assign mem_err      = r_err;

  // Two-state access FSM together with the captured request and the MEM/WB register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= 9'd0;
      r_addr        <= 32'd0;
      r_wdata       <= 32'd0;
      r_we          <= 1'b0;
      r_wbdata      <= 1'b0;
      r_regwrite    <= 1'b0;
      r_dest        <= 4'd0;
      r_pc          <= 32'd0;
      r_wb_regwrite <= 1'b0;
      r_wb_dest     <= 4'd0;
      r_wb_value    <= 32'd0;
      r_wb_pc       <= LP_BUBBLE_PC;
      r_err         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_access) begin
            r_wb_regwrite <= RegWrite_in;
            r_wb_dest     <= dest_reg_in;
            r_wb_value    <= ALU_result_in;
            r_wb_pc       <= PC_in;
          end else if (w_aligned) begin
            // Launch: capture the request, a store wins when both strobes are set.
            r_state       <= S_WAIT;
            r_cnt         <= 9'd0;
            r_addr        <= ALU_result_in;
            r_wdata       <= BusB_in;
            r_we          <= MemWrite_in;
            r_wbdata      <= WBdata_in;
            r_regwrite    <= RegWrite_in;
            r_dest        <= dest_reg_in;
            r_pc          <= PC_in;
            r_wb_regwrite <= 1'b0;
            r_wb_dest     <= 4'd0;
            r_wb_value    <= 32'd0;
            r_wb_pc       <= LP_BUBBLE_PC;
          end else begin
            // Misaligned: pass the instruction along without its register write.
            r_wb_regwrite <= 1'b0;
            r_wb_dest     <= dest_reg_in;
            r_wb_value    <= ALU_result_in;
            r_wb_pc       <= PC_in;
            r_err         <= 1'b1;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            r_state       <= S_IDLE;
            r_wb_regwrite <= r_regwrite;
            r_wb_dest     <= r_dest;
            r_wb_value    <= r_wbdata ? mem_rdata : r_addr;
            r_wb_pc       <= r_pc;
          end else if (w_timeout) begin
            // Abort: the instruction is dropped and a bubble goes down the pipe.
            r_state       <= S_IDLE;
            r_cnt         <= 9'd0;
            r_wb_regwrite <= 1'b0;
            r_wb_dest     <= 4'd0;
            r_wb_value    <= 32'd0;
            r_wb_pc       <= LP_BUBBLE_PC;
            r_err         <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with TIMEOUT=4.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
// Each check is an immediate assertion that counts and reports any miscompare.
module tb_mem_stage_ctrl;

  logic        clk;
  logic        reset_n;
  logic        MemRead_in, MemWrite_in, WBdata_in, RegWrite_in;
  logic [31:0] ALU_result_in, BusB_in, PC_in;
  logic [3:0]  dest_reg_in;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_out, RegWrite_out, mem_err;
  logic [3:0]  dest_reg_out;
  logic [31:0] WB_value_out, PC_out;

  int n_vec = 0;
  int n_err = 0;

  mem_stage_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .WBdata_in(WBdata_in), .RegWrite_in(RegWrite_in),
    .ALU_result_in(ALU_result_in), .BusB_in(BusB_in),
    .dest_reg_in(dest_reg_in), .PC_in(PC_in),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_out(stall_out),
    .RegWrite_out(RegWrite_out), .dest_reg_out(dest_reg_out),
    .WB_value_out(WB_value_out), .PC_out(PC_out),
    .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic wbd, input logic rw,
                       input logic [31:0] alu, input logic [31:0] busb,
                       input logic [3:0] dst, input logic [31:0] pc);
    MemRead_in = rd; MemWrite_in = wr; WBdata_in = wbd; RegWrite_in = rw;
    ALU_result_in = alu; BusB_in = busb; dest_reg_in = dst; PC_in = pc;
  endtask

  initial begin
    reset_n = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    drive(0, 0, 0, 0, 32'd0, 32'd0, 4'd0, 32'd0);
    #12;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_pc", PC_out, 32'hFFFF_FFFF);
    chk("rst_regwrite", {31'd0, RegWrite_out}, 32'd0);
    chk("rst_wb", WB_value_out, 32'd0);
    chk("rst_err", {31'd0, mem_err}, 32'd0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    reset_n = 1'b1;
    tick();

    // ALU-only instruction: latency 1, no stall.
    drive(0, 0, 0, 1, 32'h1234, 32'd0, 4'h3, 32'h10);
    #1 chk("alu_stall", {31'd0, stall_out}, 32'd0);
    tick();
    chk("alu_regwrite", {31'd0, RegWrite_out}, 32'd1);
    chk("alu_dest", {28'd0, dest_reg_out}, 32'd3);
    chk("alu_wb", WB_value_out, 32'h1234);
    chk("alu_pc", PC_out, 32'h10);

    // Load, ack in the third WAIT cycle.
    drive(1, 0, 1, 1, 32'h100, 32'd0, 4'h5, 32'h20);
    #1 chk("ld_launch_stall", {31'd0, stall_out}, 32'd1);
    chk("ld_launch_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("ld_w1_req", {31'd0, mem_req}, 32'd1);
    chk("ld_w1_addr", mem_addr, 32'h100);
    chk("ld_w1_we", {31'd0, mem_we}, 32'd0);
    chk("ld_bubble_rw", {31'd0, RegWrite_out}, 32'd0);
    chk("ld_bubble_pc", PC_out, 32'hFFFF_FFFF);
    chk("ld_w1_stall", {31'd0, stall_out}, 32'd1);
    drive(0, 1, 0, 0, 32'hBAD0, 32'h1111, 4'hE, 32'h99);
    tick();
    chk("ld_w2_req", {31'd0, mem_req}, 32'd1);
    chk("ld_w2_addr", mem_addr, 32'h100);
    chk("ld_w2_stall", {31'd0, stall_out}, 32'd1);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_BABE;
    #1 chk("ld_w3_stall", {31'd0, stall_out}, 32'd0);
    chk("ld_w3_req", {31'd0, mem_req}, 32'd1);
    // Store with both strobes set: must be a write; issued the cycle after the ack.
    drive(1, 1, 0, 0, 32'h200, 32'hDEAD_BEEF, 4'h7, 32'h30);
    tick();
    mem_ack = 1'b0;
    chk("ld_wb", WB_value_out, 32'hCAFE_BABE);
    chk("ld_regwrite", {31'd0, RegWrite_out}, 32'd1);
    chk("ld_dest", {28'd0, dest_reg_out}, 32'd5);
    chk("ld_pc", PC_out, 32'h20);
    chk("ld_done_req", {31'd0, mem_req}, 32'd0);
    #1 chk("st_launch_stall", {31'd0, stall_out}, 32'd1);
    tick();
    chk("st_req", {31'd0, mem_req}, 32'd1);
    chk("st_we", {31'd0, mem_we}, 32'd1);
    chk("st_addr", mem_addr, 32'h200);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h55;
    #1 chk("st_ack_stall", {31'd0, stall_out}, 32'd0);
    tick();
    mem_ack = 1'b0;
    chk("st_regwrite", {31'd0, RegWrite_out}, 32'd0);
    chk("st_wb_addr", WB_value_out, 32'h200);
    chk("st_pc", PC_out, 32'h30);
    chk("st_done_we", {31'd0, mem_we}, 32'd0);
    chk("st_done_req", {31'd0, mem_req}, 32'd0);

    // Ack in the very cycle the count would reach TIMEOUT: the ack wins.
    drive(1, 0, 1, 1, 32'h300, 32'd0, 4'h9, 32'h40);
    tick();
    drive(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    tick();
    tick();
    tick();
    chk("race_w4_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    chk("race_wb", WB_value_out, 32'h1234_5678);
    chk("race_regwrite", {31'd0, RegWrite_out}, 32'd1);
    chk("race_pc", PC_out, 32'h40);
    chk("race_err", {31'd0, mem_err}, 32'd0);
    chk("race_req", {31'd0, mem_req}, 32'd0);

    // Timeout: no ack for 4 WAIT cycles.
    drive(1, 0, 1, 1, 32'h400, 32'd0, 4'hA, 32'h50);
    tick();
    drive(0, 0, 0, 1, 32'h777, 32'd0, 4'h2, 32'h60);
    tick();
    tick();
    tick();
    chk("to_w4_req", {31'd0, mem_req}, 32'd1);
    chk("to_w4_stall", {31'd0, stall_out}, 32'd1);
    tick();
    chk("to_req", {31'd0, mem_req}, 32'd0);
    chk("to_err", {31'd0, mem_err}, 32'd1);
    chk("to_bubble_rw", {31'd0, RegWrite_out}, 32'd0);
    chk("to_bubble_pc", PC_out, 32'hFFFF_FFFF);
    chk("to_stall", {31'd0, stall_out}, 32'd0);
    // Ack in IDLE is ignored; pipeline keeps flowing and mem_err stays set.
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_req", {31'd0, mem_req}, 32'd0);
    chk("after_to_wb", WB_value_out, 32'h777);
    chk("after_to_pc", PC_out, 32'h60);
    chk("after_to_rw", {31'd0, RegWrite_out}, 32'd1);
    chk("err_sticky", {31'd0, mem_err}, 32'd1);

    // Reset during the second WAIT cycle.
    drive(1, 0, 1, 1, 32'h500, 32'd0, 4'h1, 32'h80);
    tick();
    drive(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    tick();
    chk("rw_w2_req", {31'd0, mem_req}, 32'd1);
    #2 reset_n = 1'b0;
    #1 chk("rw_req", {31'd0, mem_req}, 32'd0);
    chk("rw_pc", PC_out, 32'hFFFF_FFFF);
    chk("rw_err", {31'd0, mem_err}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rw_idle_req", {31'd0, mem_req}, 32'd0);
    chk("rw_idle_stall", {31'd0, stall_out}, 32'd0);

    // Misaligned load: no request, no stall, register write suppressed, error set.
    drive(1, 0, 1, 1, 32'h102, 32'd0, 4'h4, 32'h70);
    #1 chk("mis_stall", {31'd0, stall_out}, 32'd0);
    chk("mis_req0", {31'd0, mem_req}, 32'd0);
    tick();
    drive(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    chk("mis_req", {31'd0, mem_req}, 32'd0);
    chk("mis_regwrite", {31'd0, RegWrite_out}, 32'd0);
    chk("mis_err", {31'd0, mem_err}, 32'd1);
    chk("mis_pc", PC_out, 32'h70);
    chk("mis_dest", {28'd0, dest_reg_out}, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
